idma_dv_port: RTL and testbench

IDMA_DV_PORT -- requirements
Module: idma_dv_port

---
 rtl/idma_dv_port_if.sv | 53 +++++
 rtl/idma_dv_port.sv | 140 ++++++++++++++
 tb/tb_idma_dv_port.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idma_dv_port_if.sv
// Descriptor-port bundle between a launcher (master) and the idma_dv_port front-end (slave).
// Signal names keep their port-style suffixes so they read the same on both sides.
interface idma_dv_port_if #(
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned TFLenWidth = 32
);
    logic                  launch_i;
    logic                  launch_ready_o;
    logic [TFLenWidth-1:0] length_i;
    logic [AddrWidth-1:0]  src_addr_i;
    logic [AddrWidth-1:0]  dst_addr_i;
    logic [9:0]            opt_i;
    logic [TFLenWidth-1:0] req_length_o;
    logic [AddrWidth-1:0]  req_src_addr_o;
    logic [AddrWidth-1:0]  req_dst_addr_o;
    logic [9:0]            req_opt_o;
    logic                  req_valid_o;
    logic                  req_ready_i;
    logic                  rsp_valid_i;
    logic                  rsp_ready_o;
    logic                  rsp_error_i;
    logic [AddrWidth-1:0]  rsp_err_addr_i;
    logic                  done_o;
    logic                  err_o;
    logic [AddrWidth-1:0]  err_addr_o;
    logic                  eh_launch_i;
    logic                  eh_action_i;
    logic                  eh_req_o;
    logic                  eh_req_valid_o;
    logic                  eh_req_ready_i;
    logic                  busy_o;
    logic [15:0]           req_cnt_o;
    logic [15:0]           rsp_cnt_o;
    logic                  stall_o;

    modport slave (
        input  launch_i, length_i, src_addr_i, dst_addr_i, opt_i,
        input  req_ready_i, rsp_valid_i, rsp_error_i, rsp_err_addr_i,
        input  eh_launch_i, eh_action_i, eh_req_ready_i,
        output launch_ready_o, req_length_o, req_src_addr_o, req_dst_addr_o, req_opt_o,
        output req_valid_o, rsp_ready_o, done_o, err_o, err_addr_o,
        output eh_req_o, eh_req_valid_o, busy_o, req_cnt_o, rsp_cnt_o, stall_o
    );

    modport master (
        output launch_i, length_i, src_addr_i, dst_addr_i, opt_i,
        output req_ready_i, rsp_valid_i, rsp_error_i, rsp_err_addr_i,
        output eh_launch_i, eh_action_i, eh_req_ready_i,
        input  launch_ready_o, req_length_o, req_src_addr_o, req_dst_addr_o, req_opt_o,
        input  req_valid_o, rsp_ready_o, done_o, err_o, err_addr_o,
        input  eh_req_o, eh_req_valid_o, busy_o, req_cnt_o, rsp_cnt_o, stall_o
    );
endinterface

// File: rtl/idma_dv_port.sv
// Single-entry descriptor front-end for an iDMA backend: registers one launch at a time,
// tracks outstanding transfers, holds the first error until resolved, and flags stalls.
module idma_dv_port #(
    parameter int unsigned AddrWidth         = 32,
    parameter int unsigned TFLenWidth        = 32,
    parameter int unsigned WatchDogNumCycles = 100
) (
    input logic            clk_i,
    input logic            rst_i,
    idma_dv_port_if.slave  port
);
    localparam int unsigned        WdWidth = $clog2(WatchDogNumCycles + 1);
    localparam logic [WdWidth-1:0] WdLimit = WdWidth'(WatchDogNumCycles);

    logic                  req_valid_q;
    logic [TFLenWidth-1:0] req_length_q;
    logic [AddrWidth-1:0]  req_src_q;
    logic [AddrWidth-1:0]  req_dst_q;
    logic [9:0]            req_opt_q;
    logic [7:0]            outstanding_q;
    logic                  done_q;
    logic                  err_q;
    logic [AddrWidth-1:0]  err_addr_q;
    logic                  eh_req_q;
    logic                  eh_valid_q;
    logic [15:0]           req_cnt_q;
    logic [15:0]           rsp_cnt_q;
    logic [WdWidth-1:0]    wd_q;
    logic [WdWidth-1:0]    wd_next;
    logic                  stall_q;

    logic launch_ready;
    logic rsp_ready;
    logic busy;
    logic launch_hs;
    logic req_hs;
    logic rsp_hs;
    logic eh_hs;
    logic waiting;

    // Outstanding is capped at 255 by refusing new launches once it is full.
    assign launch_ready = !req_valid_q && (outstanding_q != 8'hFF);
    assign rsp_ready    = !err_q;
    assign busy         = req_valid_q || (outstanding_q != 8'd0);
    assign launch_hs    = port.launch_i && launch_ready;
    assign req_hs       = req_valid_q && port.req_ready_i;
    assign rsp_hs       = port.rsp_valid_i && rsp_ready;
    assign eh_hs        = eh_valid_q && port.eh_req_ready_i;
    assign waiting      = (req_valid_q && !port.req_ready_i)
                        || ((outstanding_q != 8'd0) && !port.rsp_valid_i);

    always_comb begin
        wd_next = wd_q;
        if (req_hs || rsp_hs || eh_hs || !busy) begin
            wd_next = '0;
        end else if (waiting && (wd_q != WdLimit)) begin
            wd_next = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_valid_q   <= 1'b0;
            req_length_q  <= '0;
            req_src_q     <= '0;
            req_dst_q     <= '0;
            req_opt_q     <= '0;
            outstanding_q <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            err_addr_q    <= '0;
            eh_req_q      <= 1'b0;
            eh_valid_q    <= 1'b0;
            req_cnt_q     <= '0;
            rsp_cnt_q     <= '0;
            wd_q          <= '0;
            stall_q       <= 1'b0;
        end else begin
            if (launch_hs) begin
                req_valid_q  <= 1'b1;
                req_length_q <= port.length_i;
                req_src_q    <= port.src_addr_i;
                req_dst_q    <= port.dst_addr_i;
                req_opt_q    <= port.opt_i;
            end else if (req_hs) begin
                req_valid_q <= 1'b0;
            end

            // A request and a response in the same cycle cancel out.
            if (req_hs && !rsp_hs) begin
                outstanding_q <= outstanding_q + 8'd1;
            end else if (rsp_hs && !req_hs && (outstanding_q != 8'd0)) begin
                outstanding_q <= outstanding_q - 8'd1;
            end

            done_q <= rsp_hs && !port.rsp_error_i;

            if (rsp_hs && port.rsp_error_i) begin
                err_q      <= 1'b1;
                err_addr_q <= port.rsp_err_addr_i;
            end else if (eh_hs) begin
                err_q <= 1'b0;
            end

            if (port.eh_launch_i && err_q && !eh_valid_q) begin
                eh_valid_q <= 1'b1;
                eh_req_q   <= port.eh_action_i;
            end else if (eh_hs) begin
                eh_valid_q <= 1'b0;
            end

            if (req_hs) begin
                req_cnt_q <= req_cnt_q + 16'd1;
            end
            if (rsp_hs) begin
                rsp_cnt_q <= rsp_cnt_q + 16'd1;
            end

            wd_q    <= wd_next;
            stall_q <= (wd_next == WdLimit);
        end
    end

    assign port.launch_ready_o = launch_ready;
    assign port.rsp_ready_o    = rsp_ready;
    assign port.busy_o         = busy;
    assign port.req_valid_o    = req_valid_q;
    assign port.req_length_o   = req_length_q;
    assign port.req_src_addr_o = req_src_q;
    assign port.req_dst_addr_o = req_dst_q;
    assign port.req_opt_o      = req_opt_q;
    assign port.done_o         = done_q;
    assign port.err_o          = err_q;
    assign port.err_addr_o     = err_addr_q;
    assign port.eh_req_o       = eh_req_q;
    assign port.eh_req_valid_o = eh_valid_q;
    assign port.req_cnt_o      = req_cnt_q;
    assign port.rsp_cnt_o      = rsp_cnt_q;
    assign port.stall_o        = stall_q;
endmodule

// File: tb/tb_idma_dv_port.sv
// Self-checking bench for idma_dv_port: directed scenarios plus randomized traffic,
// all compared against a transaction-level reference model.
module tb_idma_dv_port;
    localparam int AW = 32;
    localparam int LW = 32;
    localparam int WD = 100;

    typedef struct {
        logic [LW-1:0] len;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [9:0]    opt;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    idma_dv_port_if #(.AddrWidth(AW), .TFLenWidth(LW)) dv_if ();

    idma_dv_port #(
        .AddrWidth(AW),
        .TFLenWidth(LW),
        .WatchDogNumCycles(WD)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .port (dv_if)
    );

    int checkCount = 0;
    int errorCount = 0;

    req_t          pendQ[$];
    bit            ehQ[$];
    int            nOut;
    bit            errPend;
    logic [AW-1:0] errAddr;
    bit            doneExp;
    int            reqCount;
    int            rspCount;
    int            wdog;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        pendQ.delete();
        ehQ.delete();
        nOut     = 0;
        errPend  = 1'b0;
        errAddr  = '0;
        doneExp  = 1'b0;
        reqCount = 0;
        rspCount = 0;
        wdog     = 0;
    endtask

    // Advances the reference model by one clock using the inputs currently driven.
    task automatic modelStep();
        bit launchRdy, reqHs, rspHs, ehHs, busyNow, waiting, errNow, ehPendNow;
        if (rst) begin
            modelReset();
            return;
        end
        launchRdy = (pendQ.size() == 0) && (nOut != 255);
        busyNow   = (pendQ.size() != 0) || (nOut != 0);
        reqHs     = (pendQ.size() != 0) && dv_if.req_ready_i;
        rspHs     = dv_if.rsp_valid_i && !errPend;
        ehHs      = (ehQ.size() != 0) && dv_if.eh_req_ready_i;
        waiting   = ((pendQ.size() != 0) && !dv_if.req_ready_i) || ((nOut != 0) && !dv_if.rsp_valid_i);
        errNow    = errPend;
        ehPendNow = (ehQ.size() != 0);

        if (reqHs || rspHs || ehHs || !busyNow) wdog = 0;
        else if (waiting && wdog < WD) wdog = wdog + 1;

        if (reqHs) void'(pendQ.pop_front());
        if (dv_if.launch_i && launchRdy)
            pendQ.push_back('{dv_if.length_i, dv_if.src_addr_i, dv_if.dst_addr_i, dv_if.opt_i});

        nOut = nOut + int'(reqHs) - int'(rspHs);
        if (nOut < 0) nOut = 0;

        doneExp  = rspHs && !dv_if.rsp_error_i;
        reqCount = (reqCount + int'(reqHs)) % 65536;
        rspCount = (rspCount + int'(rspHs)) % 65536;

        if (ehHs) begin
            void'(ehQ.pop_front());
            errPend = 1'b0;
        end
        if (dv_if.eh_launch_i && errNow && !ehPendNow) ehQ.push_back(dv_if.eh_action_i);
        if (rspHs && dv_if.rsp_error_i) begin
            errPend = 1'b1;
            errAddr = dv_if.rsp_err_addr_i;
        end
    endtask

    task automatic compareAll();
        checkOutput("req_valid", dv_if.req_valid_o, pendQ.size() != 0);
        if (pendQ.size() != 0) begin
            checkOutput("req_length", dv_if.req_length_o, pendQ[0].len);
            checkOutput("req_src", dv_if.req_src_addr_o, pendQ[0].src);
            checkOutput("req_dst", dv_if.req_dst_addr_o, pendQ[0].dst);
            checkOutput("req_opt", dv_if.req_opt_o, pendQ[0].opt);
        end
        checkOutput("launch_ready", dv_if.launch_ready_o, (pendQ.size() == 0) && (nOut != 255));
        checkOutput("rsp_ready", dv_if.rsp_ready_o, !errPend);
        checkOutput("busy", dv_if.busy_o, (pendQ.size() != 0) || (nOut != 0));
        checkOutput("done", dv_if.done_o, doneExp);
        checkOutput("err", dv_if.err_o, errPend);
        checkOutput("err_addr", dv_if.err_addr_o, errAddr);
        checkOutput("eh_req_valid", dv_if.eh_req_valid_o, ehQ.size() != 0);
        if (ehQ.size() != 0) checkOutput("eh_req", dv_if.eh_req_o, ehQ[0]);
        checkOutput("req_cnt", dv_if.req_cnt_o, reqCount);
        checkOutput("rsp_cnt", dv_if.rsp_cnt_o, rspCount);
        checkOutput("stall", dv_if.stall_o, wdog == WD);
    endtask

    task automatic applyStimulus();
        modelStep();
        @(posedge clk);
        #1;
        compareAll();
    endtask

    task automatic clearInputs();
        dv_if.launch_i       = 1'b0;
        dv_if.length_i       = '0;
        dv_if.src_addr_i     = '0;
        dv_if.dst_addr_i     = '0;
        dv_if.opt_i          = '0;
        dv_if.req_ready_i    = 1'b0;
        dv_if.rsp_valid_i    = 1'b0;
        dv_if.rsp_error_i    = 1'b0;
        dv_if.rsp_err_addr_i = '0;
        dv_if.eh_launch_i    = 1'b0;
        dv_if.eh_action_i    = 1'b0;
        dv_if.eh_req_ready_i = 1'b0;
    endtask

    initial begin
        clearInputs();
        modelReset();
        rst = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("reset_busy", dv_if.busy_o, 0);
        checkOutput("reset_launch_ready", dv_if.launch_ready_o, 1);
        rst = 1'b0;

        // Basic launch with an immediately ready backend.
        dv_if.launch_i    = 1'b1;
        dv_if.length_i    = 32'h40;
        dv_if.src_addr_i  = 32'h1000;
        dv_if.dst_addr_i  = 32'h2000;
        dv_if.req_ready_i = 1'b1;
        applyStimulus();
        checkOutput("dir_req_valid", dv_if.req_valid_o, 1);
        checkOutput("dir_req_len", dv_if.req_length_o, 32'h40);
        checkOutput("dir_req_src", dv_if.req_src_addr_o, 32'h1000);
        checkOutput("dir_req_dst", dv_if.req_dst_addr_o, 32'h2000);
        dv_if.launch_i = 1'b0;
        applyStimulus();
        checkOutput("dir_req_cleared", dv_if.req_valid_o, 0);
        checkOutput("dir_req_cnt", dv_if.req_cnt_o, 1);
        applyStimulus();
        checkOutput("dir_busy_hold", dv_if.busy_o, 1);

        dv_if.rsp_valid_i = 1'b1;
        applyStimulus();
        checkOutput("dir_done", dv_if.done_o, 1);
        checkOutput("dir_idle", dv_if.busy_o, 0);
        checkOutput("dir_rsp_cnt", dv_if.rsp_cnt_o, 1);
        dv_if.rsp_valid_i = 1'b0;
        applyStimulus();
        checkOutput("dir_done_once", dv_if.done_o, 0);

        // Backend back-pressure: fields must hold and a second launch is dropped.
        dv_if.req_ready_i = 1'b0;
        dv_if.launch_i    = 1'b1;
        dv_if.length_i    = 32'h80;
        dv_if.src_addr_i  = 32'h3000;
        dv_if.dst_addr_i  = 32'h4000;
        dv_if.opt_i       = 10'h155;
        applyStimulus();
        dv_if.length_i   = 32'h99;
        dv_if.src_addr_i = 32'h5;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("bp_launch_ready", dv_if.launch_ready_o, 0);
            checkOutput("bp_len_stable", dv_if.req_length_o, 32'h80);
        end
        dv_if.launch_i    = 1'b0;
        dv_if.req_ready_i = 1'b1;
        applyStimulus();
        checkOutput("bp_req_cnt", dv_if.req_cnt_o, 2);

        // Error response and its resolution through the error handler.
        dv_if.rsp_valid_i    = 1'b1;
        dv_if.rsp_error_i    = 1'b1;
        dv_if.rsp_err_addr_i = 32'h2010;
        applyStimulus();
        checkOutput("eh_err", dv_if.err_o, 1);
        checkOutput("eh_err_addr", dv_if.err_addr_o, 32'h2010);
        checkOutput("eh_rsp_ready", dv_if.rsp_ready_o, 0);
        checkOutput("eh_no_done", dv_if.done_o, 0);
        dv_if.rsp_valid_i = 1'b0;
        dv_if.rsp_error_i = 1'b0;
        dv_if.eh_launch_i = 1'b1;
        dv_if.eh_action_i = 1'b1;
        applyStimulus();
        checkOutput("eh_valid", dv_if.eh_req_valid_o, 1);
        checkOutput("eh_action", dv_if.eh_req_o, 1);
        dv_if.eh_launch_i    = 1'b0;
        dv_if.eh_req_ready_i = 1'b1;
        applyStimulus();
        checkOutput("eh_resolved", dv_if.err_o, 0);
        checkOutput("eh_rsp_ready_back", dv_if.rsp_ready_o, 1);
        checkOutput("eh_addr_held", dv_if.err_addr_o, 32'h2010);
        dv_if.eh_req_ready_i = 1'b0;

        // Watchdog trips after exactly WD stalled cycles.
        dv_if.req_ready_i = 1'b0;
        dv_if.launch_i    = 1'b1;
        applyStimulus();
        dv_if.launch_i = 1'b0;
        for (int i = 0; i < WD - 1; i++) applyStimulus();
        checkOutput("wd_not_yet", dv_if.stall_o, 0);
        applyStimulus();
        checkOutput("wd_stall", dv_if.stall_o, 1);
        dv_if.req_ready_i = 1'b1;
        applyStimulus();
        checkOutput("wd_cleared", dv_if.stall_o, 0);

        // Reset with a pending request and a latched error.
        dv_if.req_ready_i    = 1'b0;
        dv_if.rsp_valid_i    = 1'b1;
        dv_if.rsp_error_i    = 1'b1;
        dv_if.rsp_err_addr_i = 32'hABC0;
        dv_if.launch_i       = 1'b1;
        applyStimulus();
        checkOutput("pre_rst_err", dv_if.err_o, 1);
        checkOutput("pre_rst_req", dv_if.req_valid_o, 1);
        dv_if.rsp_valid_i = 1'b0;
        rst = 1'b1;
        applyStimulus();
        checkOutput("rst_req_valid", dv_if.req_valid_o, 0);
        checkOutput("rst_err", dv_if.err_o, 0);
        checkOutput("rst_err_addr", dv_if.err_addr_o, 0);
        checkOutput("rst_req_len", dv_if.req_length_o, 0);
        checkOutput("rst_req_src", dv_if.req_src_addr_o, 0);
        checkOutput("rst_eh_req", dv_if.eh_req_o, 0);
        checkOutput("rst_req_cnt", dv_if.req_cnt_o, 0);
        checkOutput("rst_rsp_cnt", dv_if.rsp_cnt_o, 0);
        rst = 1'b0;
        clearInputs();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst                  = ($urandom_range(0, 199) == 0);
            dv_if.launch_i       = $urandom_range(0, 1) == 1;
            dv_if.length_i       = LW'($urandom);
            dv_if.src_addr_i     = AW'($urandom);
            dv_if.dst_addr_i     = AW'($urandom);
            dv_if.opt_i          = 10'($urandom);
            dv_if.req_ready_i    = $urandom_range(0, 9) < 7;
            dv_if.rsp_valid_i    = $urandom_range(0, 9) < 4;
            dv_if.rsp_error_i    = $urandom_range(0, 4) == 0;
            dv_if.rsp_err_addr_i = AW'($urandom);
            dv_if.eh_launch_i    = $urandom_range(0, 3) == 0;
            dv_if.eh_action_i    = $urandom_range(0, 1) == 1;
            dv_if.eh_req_ready_i = $urandom_range(0, 1) == 1;
            applyStimulus();
        end

        // Fill outstanding to its 255 ceiling with no responses returning.
        rst = 1'b1;
        clearInputs();
        applyStimulus();
        rst = 1'b0;
        dv_if.launch_i    = 1'b1;
        dv_if.req_ready_i = 1'b1;
        for (int i = 0; i < 600; i++) applyStimulus();
        checkOutput("fill_launch_blocked", dv_if.launch_ready_o, 0);
        checkOutput("fill_req_cnt", dv_if.req_cnt_o, 255);
        dv_if.launch_i    = 1'b0;
        dv_if.rsp_valid_i = 1'b1;
        applyStimulus();
        checkOutput("fill_launch_reopen", dv_if.launch_ready_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
